dds_key_ctrl: RTL

- Configuration controller between the matrix keypad scanner and the DDS core.
- Turns debounced key events (key code + keypress level) into decimal entry sequences: frequency (Hz), phase (degrees) and waveform select.
- Converts the entered BCD value to binary sequentially, range-checks it, and presents the result to the DDS with a one-cycle load strobe.

---
 rtl/dds_key_pkg.sv | 15 +
 rtl/bcd_seq2bin.sv | 35 +++
 rtl/dds_key_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/dds_key_pkg.sv
// dds_key_pkg: key codes, FSM state and mode encodings for dds_key_ctrl
package dds_key_pkg;
  localparam logic [4:0] KEY_A    = 5'd10;
  localparam logic [4:0] KEY_B    = 5'd11;
  localparam logic [4:0] KEY_C    = 5'd12;
  localparam logic [4:0] KEY_D    = 5'd13;
  localparam logic [4:0] KEY_STAR = 5'd14;
  localparam logic [4:0] KEY_HASH = 5'd15;
  localparam int PHASE_MAX = 359;
  typedef enum logic [2:0] {S_IDLE, S_FREQ, S_PHASE, S_CONV, S_APPLY} state_t;
  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_FREQ  = 2'd1;
  localparam logic [1:0] M_PHASE = 2'd2;
  localparam logic [1:0] M_CONV  = 2'd3;
endpackage

// File: rtl/bcd_seq2bin.sv
// bcd_seq2bin: sequential MSD-first BCD-to-binary converter, one digit per clock
module bcd_seq2bin #(
  parameter int DIGITS = 6,
  parameter int VAL_W  = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd,
  input  logic [2:0]          cnt,
  output logic [VAL_W-1:0]    val,
  output logic                done
);
  logic [2:0] idx;
  logic       run;
  logic [3:0] nib;
  assign nib  = bcd[4*idx +: 4];
  // done marks the cycle whose closing edge folds in the last digit
  assign done = run & (idx == 3'd0);
  // accumulate val = val*10 + digit, most significant digit first
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      val <= '0;
      idx <= '0;
      run <= 1'b0;
    end else if (start) begin
      val <= '0;
      idx <= cnt - 3'd1;
      run <= 1'b1;
    end else if (run) begin
      val <= (val << 3) + (val << 1) + VAL_W'(nib);
      idx <= idx - 3'd1;
      run <= idx != 3'd0;
    end
endmodule

// File: rtl/dds_key_ctrl.sv
// dds_key_ctrl: keypad-to-DDS configuration controller; DDS_KEY_TIMEOUT_EN enables idle entry abort
module dds_key_ctrl import dds_key_pkg::*; #(
  parameter int DIGITS      = 6,
  parameter int VAL_W       = 20,
  parameter int FREQ_RST    = 1000,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          key,
  input  logic                keypress,
  output logic [VAL_W-1:0]    freq_val,
  output logic [8:0]          phase_val,
  output logic [1:0]          wave_sel,
  output logic                cfg_load,
  output logic [4*DIGITS-1:0] entry_bcd,
  output logic [2:0]          entry_cnt,
  output logic [1:0]          mode,
  output logic                busy,
  output logic                err
);
  state_t           state;
  logic             kp_d, tgt_phase, ev, entering, is_digit, start, done, tout;
  logic [2:0]       lim;
  logic [VAL_W-1:0] acc;
  assign busy     = (state == S_CONV) || (state == S_APPLY);
  assign mode     = busy ? M_CONV : state == S_FREQ ? M_FREQ : state == S_PHASE ? M_PHASE : M_IDLE;
  assign ev       = keypress & ~kp_d & ~key[4] & ~busy;
  assign entering = (state == S_FREQ) || (state == S_PHASE);
  assign is_digit = key[3:0] < 4'd10;
  assign lim      = state == S_PHASE ? 3'd3 : 3'(DIGITS);
  assign start    = ev && entering && key == KEY_HASH && entry_cnt != 3'd0;
  bcd_seq2bin #(.DIGITS(DIGITS), .VAL_W(VAL_W)) u_conv (
    .clk(clk), .reset(reset), .start(start), .bcd(entry_bcd), .cnt(entry_cnt), .val(acc), .done(done)
  );
`ifdef DDS_KEY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] tcnt;
  assign tout = entering && !ev && tcnt == TW'(TIMEOUT_CYC - 1);
  // idle-cycle counter, live only while a value is being typed
  always_ff @(posedge clk or negedge reset)
    if (!reset) tcnt <= '0;
    else tcnt <= (!entering || ev || tout) ? '0 : tcnt + 1'b1;
`else
  assign tout = 1'b0;
`endif
  // key-event FSM with registered committed outputs and entry buffer
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= S_IDLE;
      kp_d      <= 1'b0;
      tgt_phase <= 1'b0;
      freq_val  <= VAL_W'(FREQ_RST);
      phase_val <= '0;
      wave_sel  <= '0;
      cfg_load  <= 1'b0;
      entry_bcd <= '0;
      entry_cnt <= '0;
      err       <= 1'b0;
    end else begin
      kp_d     <= keypress;
      cfg_load <= 1'b0;
      if (ev && state == S_IDLE) begin
        if (key == KEY_A || key == KEY_B) begin
          state     <= key == KEY_A ? S_FREQ : S_PHASE;
          entry_bcd <= '0;
          entry_cnt <= '0;
          err       <= 1'b0;
        end else if (key == KEY_D) begin
          wave_sel <= wave_sel + 2'd1;
          cfg_load <= 1'b1;
          err      <= 1'b0;
        end
      end else if (ev && entering && key != KEY_D) begin
        err <= 1'b0;
        if (is_digit) begin
          if (entry_cnt < lim) begin
            entry_bcd <= {entry_bcd[4*DIGITS-5:0], key[3:0]};
            entry_cnt <= entry_cnt + 3'd1;
          end else err <= 1'b1;
        end else if (key == KEY_STAR) begin
          if (entry_cnt != 3'd0) begin
            entry_bcd <= entry_bcd >> 4;
            entry_cnt <= entry_cnt - 3'd1;
          end
        end else if (key == KEY_HASH) begin
          if (entry_cnt == 3'd0) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            state     <= S_CONV;
            tgt_phase <= state == S_PHASE;
          end
        end else begin
          entry_bcd <= '0;
          entry_cnt <= '0;
          state     <= key == KEY_A ? S_FREQ : key == KEY_B ? S_PHASE : state;
        end
      end else if (tout) begin
        entry_bcd <= '0;
        entry_cnt <= '0;
        err       <= 1'b1;
        state     <= S_IDLE;
      end else if (state == S_CONV && done) state <= S_APPLY;
      else if (state == S_APPLY) begin
        state     <= S_IDLE;
        entry_bcd <= '0;
        entry_cnt <= '0;
        if (!tgt_phase) begin
          freq_val <= acc;
          cfg_load <= 1'b1;
        end else if (acc <= VAL_W'(PHASE_MAX)) begin
          phase_val <= acc[8:0];
          cfg_load  <= 1'b1;
        end else err <= 1'b1;
      end
    end
endmodule
